decoder_3to8_hold: RTL and testbench

Registered 3-to-8 one-hot decoder with enable and a valid/ready input handshake. It is the inverse of the team's 8-to-3 enable encoder. An accepted 3-bit code drives the matching one-hot output bit for a programmable number of cycles, then returns to all-zero. Used to drive select/strobe lines from code streams produced by the encoder side.

---
 rtl/decoder_3to8_hold.sv | 131 +++++++++++++
 tb/tb_decoder_3to8_hold.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8_hold.sv
// Registered 3-to-8 one-hot decoder that holds each accepted code for HOLD_CYCLES cycles.
// Optional macro DEC_RETRIGGER_EN makes the hold retriggerable by any accept while holding.
module decoder_3to8_hold #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] o,
    output logic       o_valid,
    output logic       busy
);

    localparam int CNT_W = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             accept_s;
    logic             load_s;
    logic [7:0]       o_s;
    logic             o_valid_s;
    logic             busy_s;

    // Handshake readiness; a hold in progress blocks new codes until its last cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            IDLE: in_ready = en;
`ifdef DEC_RETRIGGER_EN
            HOLD: in_ready = en;
`else
            HOLD: in_ready = en && (cnt_r == CNT_ZERO);
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign accept_s = in_valid && in_ready;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            o       <= 8'h00;
            o_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            o       <= o_s;
            o_valid <= o_valid_s;
            busy    <= busy_s;
        end
    end

    // Next-state and hold counter; dropping en discards any partial hold.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        if (!en) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_s = HOLD;
                        cnt_s   = CNT_RELOAD;
                        load_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end
                HOLD: begin
                    if (accept_s) begin
                        state_s = HOLD;
                        cnt_s   = CNT_RELOAD;
                        load_s  = 1'b1;
                    end else if (cnt_r != CNT_ZERO) begin
                        state_s = HOLD;
                        cnt_s   = cnt_r - CNT_ONE;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Next registered outputs; o is non-zero exactly while the next state is HOLD.
    always_comb begin
        o_s       = 8'h00;
        o_valid_s = 1'b0;
        busy_s    = 1'b0;
        if (state_s == HOLD) begin
            if (load_s) begin
                o_s = 8'h01 << code;
            end else begin
                o_s = o;
            end
            o_valid_s = 1'b1;
            busy_s    = 1'b1;
        end else begin
            o_s       = 8'h00;
            o_valid_s = 1'b0;
            busy_s    = 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_3to8_hold.sv
// Self-checking bench for decoder_3to8_hold: vector table, directed corner sequences,
// and random stimulus against a remaining-cycles reference model.
module tb_decoder_3to8_hold;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] o;
    logic       o_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: code being shown and number of display cycles still owed.
    int         rem = 0;
    logic [2:0] cur = 3'd0;

    decoder_3to8_hold #(.HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .code     (code),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o        (o),
        .o_valid  (o_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       valid;
        logic [2:0] code;
        logic       chk_rdy;
        logic       rdy;
        logic [7:0] o;
        logic       ov;
        logic       busy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic e);
`ifdef DEC_RETRIGGER_EN
        return e;
`else
        return e && (rem <= 1);
`endif
    endfunction

    // One clock of stimulus, checked against the model before and after the edge.
    task automatic tick(input logic r, input logic e, input logic v, input logic [2:0] c);
        logic       acc;
        logic [7:0] exp_o;
        rst = r; en = e; in_valid = v; code = c;
        #1;
        chk("in_ready", {7'd0, in_ready}, {7'd0, model_ready(e)});
        acc = v && model_ready(e);
        if (r || !e) rem = 0;
        else if (acc) begin cur = c; rem = HOLD; end
        else if (rem > 0) rem = rem - 1;
        @(posedge clk);
        #1;
        exp_o = (rem > 0) ? (8'h01 << cur) : 8'h00;
        chk("o", o, exp_o);
        chk("o_valid", {7'd0, o_valid}, {7'd0, rem > 0});
        chk("busy", {7'd0, busy}, {7'd0, rem > 0});
    endtask

    initial begin
        //          rst   en    vld   code  chkr  rdy   o      ov    busy
        vecs[0] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; code = 3'd0;

        // Reset and single-code hold from the vector table.
        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; in_valid = vecs[i].valid; code = vecs[i].code;
            #1;
            if (vecs[i].chk_rdy) chk("tbl_in_ready", {7'd0, in_ready}, {7'd0, vecs[i].rdy});
            @(posedge clk);
            #1;
            chk("tbl_o", o, vecs[i].o);
            chk("tbl_o_valid", {7'd0, o_valid}, {7'd0, vecs[i].ov});
            chk("tbl_busy", {7'd0, busy}, {7'd0, vecs[i].busy});
        end
        rem = 0;

        // Back-to-back stream 0, 7, 2 with no gap between codes.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 3'd7);
`ifndef DEC_RETRIGGER_EN
        chk("b2b_o_80", o, 8'h80);
`endif
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 3'd2);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 3'd0);
        chk("b2b_idle", o, 8'h00);

        // Enable abort at hold cycle 2, then re-accept from IDLE.
        tick(1'b0, 1'b1, 1'b1, 3'd6);
        tick(1'b0, 1'b1, 1'b0, 3'd6);
        tick(1'b0, 1'b0, 1'b0, 3'd6);
        chk("abort_o", o, 8'h00);
        tick(1'b0, 1'b0, 1'b1, 3'd1);
        tick(1'b0, 1'b1, 1'b1, 3'd1);
        chk("reenable_o", o, 8'h02);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 3'd0);

        // Backpressure then reset mid-hold: code 4 never shows.
        tick(1'b0, 1'b1, 1'b1, 3'd1);
        tick(1'b0, 1'b1, 1'b1, 3'd4);
`ifndef DEC_RETRIGGER_EN
        chk("bp_o_held", o, 8'h02);
`endif
        tick(1'b1, 1'b1, 1'b1, 3'd4);
        chk("rst_mid_o", o, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 3'd4);
        chk("rst_after_o", o, 8'h00);

`ifdef DEC_RETRIGGER_EN
        // Same-code retrigger extends the hold; different code switches immediately.
        tick(1'b0, 1'b1, 1'b1, 3'd3);
        tick(1'b0, 1'b1, 1'b1, 3'd3);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 3'd0);
        chk("retrig_ext_o", o, 8'h08);
        tick(1'b0, 1'b1, 1'b0, 3'd0);
        chk("retrig_end_o", o, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 3'd3);
        tick(1'b0, 1'b1, 1'b1, 3'd1);
        chk("retrig_switch_o", o, 8'h02);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 3'd0);
`endif

        // Randomized stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
